// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS front end: default address
//                and data widths, instruction size and the fetch FSM state
//                encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int INSTR_BYTES = 4;

  // Fetch FSM states.
  //   IF_IDLE : no request outstanding
  //   IF_WAIT : request outstanding, the returned word is kept
  //   IF_DROP : request outstanding, the returned word is discarded (flushed)
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous circular FIFO with flush. The head entry
//                is read straight out of the storage registers, so the head
//                fields are registered values.
//  Ports       : clk, reset      - clock, asynchronous active-high reset
//                flush           - empties the FIFO (beats push and pop)
//                push, push_data - write one entry (ignored when full)
//                pop             - retire the head entry (ignored when empty)
//                head_data       - current head entry
//                count/full/empty- occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage behind the program counter. Issues one
//                instruction-memory read at a time over a req/ack handshake,
//                buffers returned words in a fetch queue and presents
//                {instr, pc, pc+4} to decode with valid/ready. pc_advance
//                pulses once per word actually queued; flush kills queued
//                and in-flight fetches.
//  Ports       : clk, reset               - clock, async active-high reset
//                curAddress, pc_advance   - program counter interface
//                flush                    - branch/jump redirect
//                imem_req/addr/ack/rdata  - instruction memory handshake
//                if_valid/ready/instr/pc/pc4 - decode interface
//                fetch_err                - sticky misaligned-address flag
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import mips_pkg::*;
#(
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] curAddress,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4,
  output logic              fetch_err
);

  localparam int ENTRY_W = DATA_W + 2 * ADDR_W;
  localparam int CNT_W   = $clog2(FQ_DEPTH + 1);

  if_state_e         r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_adv;
  logic              r_err;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;

  // A word is queued only when it returns for a live request and no redirect
  // arrives in the same cycle.
  assign w_push      = (r_state == IF_WAIT) & imem_ack & ~flush;
  assign w_pop       = if_ready & ~w_empty;
  // pc+4 is formed at push time; the ADDR_W-wide sum wraps naturally.
  assign w_push_data = {imem_rdata, r_addr, r_addr + ADDR_W'(INSTR_BYTES)};

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign if_valid   = (w_count != '0);
  assign if_instr   = w_head[ENTRY_W-1 -: DATA_W];
  assign if_pc      = w_head[2*ADDR_W-1 -: ADDR_W];
  assign if_pc4     = w_head[ADDR_W-1:0];

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign pc_advance = r_adv;
  assign fetch_err  = r_err;

  // While pc_advance is high the PC has not stepped yet, so curAddress still
  // holds the word just fetched; issuing is held off for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IF_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_adv   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_adv <= 1'b0;
      case (r_state)
        IF_IDLE: begin
          if (!word_aligned(curAddress[1:0])) begin
            r_err <= 1'b1;
          end else if (!flush && !r_adv && !w_full) begin
            r_req   <= 1'b1;
            r_addr  <= curAddress;
            r_state <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (imem_ack) begin
            r_req   <= 1'b0;
            r_adv   <= ~flush;
            r_state <= IF_IDLE;
          end else if (flush) begin
            r_state <= IF_DROP;
          end
        end
        IF_DROP: begin
          // Memory must still complete the read; its data is thrown away.
          if (imem_ack) begin
            r_req   <= 1'b0;
            r_state <= IF_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IF_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. Directed stimulus pushes
//                expected decode entries into a scoreboard queue; a monitor
//                pops and compares on every accepted if_valid&if_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] curAddress;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .FQ_DEPTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .curAddress (curAddress),
    .pc_advance (pc_advance),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4),
    .fetch_err  (fetch_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bounded wait for a request, then check its address.
  task automatic wait_req(input logic [31:0] addr, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_req_seen"}, 128'(seen), 128'(1));
    if (seen) chk({name, "_addr"}, 128'(imem_addr), 128'(addr));
  endtask

  // Called at a negedge with a request pending: ack after d extra cycles,
  // returns at the negedge following the ack edge.
  task automatic serve(input int d, input logic [31:0] data);
    repeat (d) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 128'({if_instr, if_pc, if_pc4}), 128'(0));
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("pop_entry", 128'({if_instr, if_pc, if_pc4}), 128'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset      = 1'b1;
    flush      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    if_ready   = 1'b1;
    curAddress = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        128'({imem_req, pc_advance, if_valid, fetch_err, imem_addr, if_instr, if_pc, if_pc4}),
        128'(0));
    reset = 1'b0;

    // 1: single fetch at 0
    wait_req(32'h0, "t1");
    exp_q.push_back({32'hA000_0001, 32'h0000_0000, 32'h0000_0004});
    serve(0, 32'hA000_0001);
    chk("t1_pc_advance", 128'(pc_advance), 128'(1));
    chk("t1_req_dropped", 128'(imem_req), 128'(0));
    flush      = 1'b1;
    curAddress = 32'h4;
    @(negedge clk);
    chk("t1_advance_pulse", 128'(pc_advance), 128'(0));
    repeat (2) @(negedge clk);

    // 2: fill the queue with decode stalled
    if_ready   = 1'b0;
    curAddress = 32'h0;
    flush      = 1'b0;
    wait_req(32'h0, "t2a");
    exp_q.push_back({32'hB000_0000, 32'h0000_0000, 32'h0000_0004});
    serve(0, 32'hB000_0000);
    chk("t2a_pc_advance", 128'(pc_advance), 128'(1));
    curAddress = 32'h4;
    wait_req(32'h4, "t2b");
    exp_q.push_back({32'hB000_0004, 32'h0000_0004, 32'h0000_0008});
    serve(0, 32'hB000_0004);
    curAddress = 32'h8;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("t2_no_third_req", 128'(cnt), 128'(0));
    chk("t2_valid_full", 128'(if_valid), 128'(1));
    @(posedge clk);
    #1 if_ready = 1'b1;

    // 3: flush two cycles into WAIT, ack five cycles after the request
    wait_req(32'h8, "t3");
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("t3_req_held_in_drop", 128'(cnt), 128'(3));
    serve(0, 32'hC000_0008);
    chk("t3_no_advance", 128'(pc_advance), 128'(0));
    chk("t3_req_dropped", 128'(imem_req), 128'(0));
    chk("t3_not_queued", 128'(if_valid), 128'(0));

    // 4: flush in the same cycle as the ack
    wait_req(32'h8, "t4");
    imem_ack   = 1'b1;
    imem_rdata = 32'hD000_0008;
    flush      = 1'b1;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    chk("t4_no_advance", 128'(pc_advance), 128'(0));
    chk("t4_queue_empty", 128'(if_valid), 128'(0));
    chk("t4_req_dropped", 128'(imem_req), 128'(0));

    // 5: misaligned address
    curAddress = 32'h6;
    flush      = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (imem_req) cnt++;
    end
    chk("t5_no_req_misaligned", 128'(cnt), 128'(0));
    chk("t5_fetch_err_set", 128'(fetch_err), 128'(1));
    curAddress = 32'hC;
    wait_req(32'hC, "t5");
    chk("t5_fetch_err_sticky", 128'(fetch_err), 128'(1));
    exp_q.push_back({32'hE000_000C, 32'h0000_000C, 32'h0000_0010});
    serve(1, 32'hE000_000C);
    curAddress = 32'hFFFF_FFFC;

    // 6: pc+4 wrap, then reset mid-WAIT
    wait_req(32'hFFFF_FFFC, "t6");
    exp_q.push_back({32'hF000_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
    serve(0, 32'hF000_FFFC);
    chk("t6_pc_advance", 128'(pc_advance), 128'(1));
    curAddress = 32'h0;
    wait_req(32'h0, "t6_rst");
    #1 reset = 1'b1;
    #1;
    chk("t6_reset_outputs",
        128'({imem_req, pc_advance, if_valid, fetch_err, imem_addr, if_instr, if_pc, if_pc4}),
        128'(0));
    flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    chk("t6_stray_ack_no_push", 128'({if_valid, pc_advance, imem_req}), 128'(0));

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
